// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S receive/transmit blocks.
//   WIDTH_DEF / SLOT_DEF : default sample width and bclk periods per half-frame
//   CH_LEFT / CH_RIGHT   : wclk level identifying each channel
//   state_t              : frame-alignment FSM encoding
package i2s_pkg;

   localparam int unsigned WIDTH_DEF = 24;
   localparam int unsigned SLOT_DEF  = 32;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      SEARCH,
      LEFT,
      RIGHT
   } state_t;

endpackage

// File: rtl/i2s_bclk_edge.sv
// i2s_bclk_edge: registers the I2S lines into the adc_clk domain and flags
// the adc_clk cycle that follows a sampled rising edge of bclk.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bclk       : bit clock (synchronous to clk)
//   wclk       : word clock
//   sdata      : serial data
//   bclk_rise  : one-cycle strobe, bclk_q high and bclk_d low
//   wclk_q     : registered word clock
//   sdata_q    : registered serial data
module i2s_bclk_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic bclk,
   input  logic wclk,
   input  logic sdata,
   output logic bclk_rise,
   output logic wclk_q,
   output logic sdata_q
);

   logic bclk_q;
   logic bclk_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bclk_q  <= 1'b0;
         bclk_d  <= 1'b0;
         wclk_q  <= 1'b0;
         sdata_q <= 1'b0;
      end else begin
         bclk_q  <= bclk;
         bclk_d  <= bclk_q;
         wclk_q  <= wclk;
         sdata_q <= sdata;
      end
   end

   assign bclk_rise = bclk_q & ~bclk_d;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: Philips I2S receiver. Oversamples bclk/wclk/sdata in
// the adc_clk domain, aligns to the frame, and presents left/right pairs on a
// valid/ready interface.
//   adc_clk, adc_rst_n   : system clock, asynchronous active-low reset
//   i2s_bclk/wclk/sdata  : I2S bus (wclk 0 = left, 1 = right)
//   out_left, out_right  : sample pair, two's complement
//   out_valid, out_ready : pair handshake
//   locked               : frame alignment acquired
//   overrun              : pulse, completed pair dropped while output full
//   frame_err            : pulse, slot too short or too long
module i2s_rx_deserializer
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned SLOT  = SLOT_DEF
) (
   input  logic             adc_clk,
   input  logic             adc_rst_n,
   input  logic             i2s_bclk,
   input  logic             i2s_wclk,
   input  logic             i2s_sdata,
   output logic [WIDTH-1:0] out_left,
   output logic [WIDTH-1:0] out_right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic             overrun,
   output logic             frame_err
);

   localparam int unsigned CW = $clog2(SLOT + 1);
   localparam logic [CW-1:0] CNT_WORD      = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_WORD_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_SLOT      = CW'(SLOT);
   localparam logic [CW-1:0] CNT_SLOT_LAST = CW'(SLOT - 1);
   localparam logic [CW-1:0] CNT_ONE       = CW'(1);

   logic             bclk_rise;
   logic             wclk_q;
   logic             sdata_q;

   state_t           state;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] shift_reg;
   logic             wclk_prev;
   logic [WIDTH-1:0] left_hold;
   logic [WIDTH-1:0] pair_left;
   logic [WIDTH-1:0] pair_right;
   logic             pair_pend;

   logic             boundary;
   logic             word_done;
   logic             slot_over;
   logic [WIDTH-1:0] captured;

   i2s_bclk_edge u_edge (
      .clk       (adc_clk),
      .rst_n     (adc_rst_n),
      .bclk      (i2s_bclk),
      .wclk      (i2s_wclk),
      .sdata     (i2s_sdata),
      .bclk_rise (bclk_rise),
      .wclk_q    (wclk_q),
      .sdata_q   (sdata_q)
   );

   // The rise that sees a new wclk level carries the previous slot's last
   // bit (one-bclk Philips delay), so it only restarts the count.
   always_comb begin
      boundary  = bclk_rise && (wclk_q != wclk_prev);
      word_done = bclk_rise && !boundary && (bit_cnt == CNT_WORD_LAST);
      slot_over = bclk_rise && !boundary && (bit_cnt == CNT_SLOT_LAST);
      captured  = {shift_reg[WIDTH-2:0], sdata_q};
   end

   // Bit counter and MSB-first shift register.
   always_ff @(posedge adc_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
         wclk_prev <= 1'b0;
      end else if (bclk_rise) begin
         wclk_prev <= wclk_q;
         if (boundary) begin
            bit_cnt <= '0;
         end else begin
            if (bit_cnt < CNT_WORD) begin
               shift_reg <= captured;
            end
            if (bit_cnt != CNT_SLOT) begin
               bit_cnt <= bit_cnt + CNT_ONE;
            end
         end
      end
   end

   // Frame-alignment FSM with registered status outputs. pair_pend is the
   // one-cycle hand-off to the output buffer.
   always_ff @(posedge adc_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         state      <= SEARCH;
         left_hold  <= '0;
         pair_left  <= '0;
         pair_right <= '0;
         pair_pend  <= 1'b0;
         locked     <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         pair_pend <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            SEARCH: begin
               if (boundary && (wclk_q == CH_LEFT)) begin
                  state <= LEFT;
               end
            end
            LEFT: begin
               if ((boundary && (bit_cnt < CNT_WORD)) || slot_over) begin
                  frame_err <= 1'b1;
                  locked    <= 1'b0;
                  state     <= SEARCH;
               end else if (boundary && (wclk_q == CH_RIGHT)) begin
                  state <= RIGHT;
               end else if (word_done) begin
                  left_hold <= captured;
               end
            end
            RIGHT: begin
               if ((boundary && (bit_cnt < CNT_WORD)) || slot_over) begin
                  frame_err <= 1'b1;
                  locked    <= 1'b0;
                  state     <= SEARCH;
               end else if (boundary && (wclk_q == CH_LEFT)) begin
                  state <= LEFT;
               end else if (word_done) begin
                  pair_left  <= left_hold;
                  pair_right <= captured;
                  pair_pend  <= 1'b1;
                  locked     <= 1'b1;
               end
            end
            default: begin
               state <= SEARCH;
            end
         endcase
      end
   end

   // Output buffer: a new pair may replace the held one only when the held
   // one is transferring in the same cycle.
   always_ff @(posedge adc_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         out_left  <= '0;
         out_right <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (pair_pend) begin
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end else begin
               out_left  <= pair_left;
               out_right <= pair_right;
               out_valid <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
module tb_i2s_rx_deserializer;

   localparam int W = 24;

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         bclk = 1'b0;
   logic         wclk = 1'b1;
   logic         sdata = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_left;
   logic [W-1:0] out_right;
   logic         out_valid;
   logic         locked;
   logic         overrun;
   logic         frame_err;

   exp_t q[$];
   exp_t e;
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   ovr_cnt = 0;
   int   err_cnt = 0;
   int   pres = 0;
   bit   prev_valid = 1'b0;
   bit   prev_xfer = 1'b0;
   bit   rdy_hook = 1'b0;

   i2s_rx_deserializer #(.WIDTH(24), .SLOT(32)) dut (
      .adc_clk   (clk),
      .adc_rst_n (rst_n),
      .i2s_bclk  (bclk),
      .i2s_wclk  (wclk),
      .i2s_sdata (sdata),
      .out_left  (out_left),
      .out_right (out_right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One bclk period of 8 adc_clk cycles; data and wclk change on the falling edge.
   task automatic send_bit(input logic ws, input logic b, input bit last_r,
                           input bit push, input logic [W-1:0] l, input logic [W-1:0] r);
      exp_t x;
      bclk = 1'b0;
      wclk = ws;
      sdata = b;
      tick(4);
      bclk = 1'b1;
      if (last_r && push) begin
         x.l = l;
         x.r = r;
         x.due = cyc + 3;
         q.push_back(x);
      end
      if (last_r && rdy_hook) begin
         tick(2);
         out_ready = 1'b1;
         tick(2);
      end else begin
         tick(4);
      end
   endtask

   // Slot bit 0 is the delayed bit after the wclk change; data MSB at bit 1.
   task automatic send_slot(input logic ws, input logic [W-1:0] word, input int nbits,
                            input bit push, input logic [W-1:0] l);
      logic b;
      for (int i = 0; i < nbits; i++) begin
         b = (i >= 1 && i <= W) ? word[W-i] : 1'b0;
         send_bit(ws, b, (ws == 1'b1) && (i == W), push, l, word);
      end
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit push);
      send_slot(1'b0, l, 32, 1'b0, l);
      send_slot(1'b1, r, 32, push, l);
   endtask

   // Monitor: counts pulses, pops the scoreboard on every transfer.
   always @(negedge clk) begin
      if (overrun) ovr_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid && (!prev_valid || prev_xfer)) pres = cyc;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pair: got %h/%h, required no transfer", out_left, out_right);
         end else begin
            e = q.pop_front();
            chk("pair_left", 32'(out_left), 32'(e.l));
            chk("pair_right", 32'(out_right), 32'(e.r));
            chk("pair_latency", pres, e.due);
         end
      end
      prev_xfer = out_valid && out_ready;
      prev_valid = out_valid;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      tick(3);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_left", 32'(out_left), 0);
      chk("rst_right", 32'(out_right), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_overrun", 32'(overrun), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      rst_n = 1'b1;
      tick(2);
      send_slot(1'b1, '0, 32, 1'b0, '0);

      // 1: basic pair
      out_ready = 1'b1;
      send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b1);
      chk("t1_locked", 32'(locked), 1);
      chk("t1_valid_done", 32'(out_valid), 0);

      // 2: extreme values
      send_frame(24'h800000, 24'h7FFFFF, 1'b1);

      // 3: stalled consumer, second pair dropped
      out_ready = 1'b0;
      send_frame(24'h111111, 24'h222222, 1'b1);
      send_frame(24'h333333, 24'h444444, 1'b0);
      chk("t3_overrun_cnt", ovr_cnt, 1);
      chk("t3_held_valid", 32'(out_valid), 1);
      chk("t3_held_left", 32'(out_left), 32'h111111);
      chk("t3_held_right", 32'(out_right), 32'h222222);
      out_ready = 1'b1;
      tick(2);
      chk("t3_drained", 32'(out_valid), 0);

      // 4: ready rises as the next pair completes
      out_ready = 1'b0;
      send_frame(24'h123456, 24'h654321, 1'b1);
      rdy_hook = 1'b1;
      send_frame(24'hABCDEF, 24'hFEDCBA, 1'b1);
      rdy_hook = 1'b0;
      chk("t4_overrun_cnt", ovr_cnt, 1);
      chk("t4_drained", 32'(out_valid), 0);

      // 5: short left slot
      send_slot(1'b0, 24'hFFFFFF, 11, 1'b0, '0);
      send_slot(1'b1, '0, 32, 1'b0, '0);
      chk("t5_err_cnt", err_cnt, 1);
      chk("t5_unlocked", 32'(locked), 0);
      send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1);
      chk("t5_relocked", 32'(locked), 1);

      // 6: reset in the middle of a right slot
      out_ready = 1'b0;
      send_frame(24'h111000, 24'h000111, 1'b0);
      send_slot(1'b0, 24'h765432, 32, 1'b0, '0);
      send_slot(1'b1, 24'h234567, 12, 1'b0, '0);
      chk("t6_pre_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 0);
      chk("t6_rst_left", 32'(out_left), 0);
      chk("t6_rst_right", 32'(out_right), 0);
      chk("t6_rst_locked", 32'(locked), 0);
      tick(3);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      out_ready = 1'b1;
      send_frame(24'hC0FFEE, 24'hBADA55, 1'b1);
      tick(4);
      chk("end_queue_empty", q.size(), 0);
      chk("end_overrun_cnt", ovr_cnt, 1);
      chk("end_err_cnt", err_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
